ro_race_arbiter: RTL and testbench



---
 rtl/ro_puf_pkg.sv | 22 ++
 rtl/ro_race_arbiter_if.sv | 60 ++++++
 rtl/ro_race_wdog.sv | 35 +++
 rtl/ro_race_arbiter.sv | 174 +++++++++++++++++
 tb/tb_ro_race_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ro_puf_pkg.sv
// Shared types and defaults for the RO race arbiter slice.
// FSM state enum, default sizes, tie-retry limit, width helper.
package ro_puf_pkg;

  localparam int N_BITS_DEF    = 8;
  localparam int PAIR_W_DEF    = 3;
  localparam int WDOG_W_DEF    = 20;
  localparam int MAX_TIE_RETRY = 3;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RACE,
    RECORD,
    DONE
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ro_race_arbiter_if.sv
// Host + counter-bank bus of the RO race arbiter.
// slave: arbiter side; master: host/counter side.
// Optional RO_PUF_TIE_RETRY_EN adds tie_seen.
interface ro_race_arbiter_if
  import ro_puf_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEF,
  parameter int PAIR_W = PAIR_W_DEF
) ();

  logic              start;
  logic [PAIR_W-1:0] challenge;
  logic              done_a;
  logic              done_b;
  logic [PAIR_W-1:0] pair_sel;
  logic              ctr_rst;
  logic              ctr_en;
  logic              busy;
  logic [N_BITS-1:0] response;
  logic              resp_valid;
  logic              wdog_err;
`ifdef RO_PUF_TIE_RETRY_EN
  logic              tie_seen;
`endif

  modport slave (
    input  start,
    input  challenge,
    input  done_a,
    input  done_b,
    output pair_sel,
    output ctr_rst,
    output ctr_en,
    output busy,
    output response,
    output resp_valid,
`ifdef RO_PUF_TIE_RETRY_EN
    output tie_seen,
`endif
    output wdog_err
  );

  modport master (
    output start,
    output challenge,
    output done_a,
    output done_b,
    input  pair_sel,
    input  ctr_rst,
    input  ctr_en,
    input  busy,
    input  response,
    input  resp_valid,
`ifdef RO_PUF_TIE_RETRY_EN
    input  tie_seen,
`endif
    input  wdog_err
  );

endinterface

// File: rtl/ro_race_wdog.sv
// Race watchdog: loadable up-counter with clear and terminal flag.
// Ports: clk, rst, i_clr, i_en, i_ld, i_ld_val in; o_tc out.
module ro_race_wdog #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic         i_ld,
  input  logic [W-1:0] i_ld_val,
  output logic         o_tc
);

  // o_tc fires in the cycle whose increment reaches all-ones,
  // so a race lasts exactly 2^W-1 enabled cycles.
  localparam logic [W-1:0] PRE_LAST = ~W'(1);

  logic [W-1:0] r_cnt;

  assign o_tc = i_en && (r_cnt == PRE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_ld) begin
      r_cnt <= i_ld_val;
    end else if (i_en) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/ro_race_arbiter.sv
// RO race arbiter: per bit, clear a pair, race it, record A-first.
// Ports: clk, rst, bus (ro_race_arbiter_if.slave). RO_PUF_TIE_RETRY_EN.
module ro_race_arbiter
  import ro_puf_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEF,
  parameter int PAIR_W = PAIR_W_DEF,
  parameter int WDOG_W = WDOG_W_DEF
) (
  input logic              clk,
  input logic              rst,
  ro_race_arbiter_if.slave bus
);

  localparam int IDX_W = idx_w(N_BITS);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(N_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_t            r_state;
  logic [PAIR_W-1:0] r_base;
  logic [PAIR_W-1:0] r_pair;
  logic [IDX_W-1:0]  r_bit;
  logic              r_win;
  logic              r_ctr_rst;
  logic              r_ctr_en;
  logic              r_busy;
  logic              r_valid;
  logic              r_werr;
  logic [N_BITS-1:0] r_resp;
`ifdef RO_PUF_TIE_RETRY_EN
  localparam logic [1:0] RETRY_MAX = 2'(MAX_TIE_RETRY);
  logic [1:0]        r_retry;
  logic              r_tie;
`endif

  logic              w_a_only;
  logic              w_tie;
  logic              w_tc;
  logic              w_exit;
  logic              w_wd_clr;
  logic              w_wd_en;
  logic [PAIR_W-1:0] w_next_pair;

  // done flags come straight from the counter flops
  assign w_a_only = bus.done_a & ~bus.done_b;
  assign w_tie    = bus.done_a &  bus.done_b;
  assign w_exit   = bus.done_a | bus.done_b | w_tc;

  assign w_wd_en  = (r_state == RACE);
  assign w_wd_clr = (r_state == CLEAR) || (r_state == RECORD);

  // wraps naturally at 2^PAIR_W
  assign w_next_pair = r_base + PAIR_W'(r_bit + IDX_ONE);

  ro_race_wdog #(
    .W(WDOG_W)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_wd_clr),
    .i_en     (w_wd_en),
    .i_ld     (1'b0),
    .i_ld_val ('0),
    .o_tc     (w_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_base    <= '0;
      r_pair    <= '0;
      r_bit     <= '0;
      r_win     <= 1'b0;
      r_ctr_rst <= 1'b0;
      r_ctr_en  <= 1'b0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_werr    <= 1'b0;
      r_resp    <= '0;
`ifdef RO_PUF_TIE_RETRY_EN
      r_retry   <= '0;
      r_tie     <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_base    <= bus.challenge;
            r_pair    <= bus.challenge;
            r_bit     <= '0;
            r_resp    <= '0;
            r_werr    <= 1'b0;
            r_busy    <= 1'b1;
            r_ctr_rst <= 1'b1;
`ifdef RO_PUF_TIE_RETRY_EN
            r_retry   <= '0;
            r_tie     <= 1'b0;
`endif
            r_state   <= CLEAR;
          end
        end
        CLEAR: begin
          r_ctr_rst <= 1'b0;
          r_ctr_en  <= 1'b1;
          r_state   <= RACE;
        end
        RACE: begin
          if (w_exit) begin
            r_ctr_en <= 1'b0;
            if (w_tc && !bus.done_a && !bus.done_b) begin
              r_werr <= 1'b1;
            end
`ifdef RO_PUF_TIE_RETRY_EN
            if (w_tie) begin
              r_tie <= 1'b1;
            end
            if (w_tie && (r_retry != RETRY_MAX)) begin
              r_retry   <= r_retry + 2'd1;
              r_ctr_rst <= 1'b1;
              r_state   <= CLEAR;
            end else begin
              r_win   <= w_a_only;
              r_state <= RECORD;
            end
`else
            // a tie leaves A-only low, so it records 0
            r_win   <= w_a_only;
            r_state <= RECORD;
`endif
          end
        end
        RECORD: begin
          r_resp[r_bit] <= r_win;
`ifdef RO_PUF_TIE_RETRY_EN
          r_retry <= '0;
`endif
          if (r_bit == LAST_BIT) begin
            r_valid <= 1'b1;
            r_state <= DONE;
          end else begin
            r_bit     <= r_bit + IDX_ONE;
            r_pair    <= w_next_pair;
            r_ctr_rst <= 1'b1;
            r_state   <= CLEAR;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // w_tie only matters for the retry path
  logic w_unused;
  assign w_unused = w_tie;

  assign bus.pair_sel   = r_pair;
  assign bus.ctr_rst    = r_ctr_rst;
  assign bus.ctr_en     = r_ctr_en;
  assign bus.busy       = r_busy;
  assign bus.response   = r_resp;
  assign bus.resp_valid = r_valid;
  assign bus.wdog_err   = r_werr;
`ifdef RO_PUF_TIE_RETRY_EN
  assign bus.tie_seen   = r_tie;
`endif

endmodule

// File: tb/tb_ro_race_arbiter.sv
// Bench for ro_race_arbiter: timeline model + per-cycle compare.
// Directed scenarios plus randomized races.
module tb_ro_race_arbiter;

  localparam int NB   = 8;
  localparam int PW   = 3;
  localparam int WW   = 4;
  localparam int WMAX = 15;

  localparam int S_CLR  = 1;
  localparam int S_RACE = 2;
  localparam int S_REC  = 3;
  localparam int S_DONE = 4;

`ifdef RO_PUF_TIE_RETRY_EN
  localparam bit TIE_EN = 1'b1;
`else
  localparam bit TIE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ro_race_arbiter_if #(.N_BITS(NB), .PAIR_W(PW)) ifc ();

  ro_race_arbiter #(
    .N_BITS(NB),
    .PAIR_W(PW),
    .WDOG_W(WW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  typedef struct {
    int         st;
    int         bt;
    int         pr;
    int         rc;
    int         ta;
    int         tb;
    logic [7:0] resp;
    logic       werr;
    logic       tie;
  } ent_t;

  ent_t exp_q[$];
  int   rq_a[$];
  int   rq_b[$];
  int   psq[$];

  int tests = 0;
  int fails = 0;

  logic [7:0] idle_resp = '0;
  logic       idle_werr = 1'b0;
  logic       idle_tie  = 1'b0;
  bit         cur_idle  = 1'b1;
  int         cur_st    = 0;
  int         cur_bit   = 0;
  int         cur_rc    = 0;
  int         last_len  = 0;

  function automatic int fst(input int t);
    return (t == 0) ? 1000 : t;
  endfunction

  // Whole-challenge expected timeline, one entry per cycle.
  task automatic build(input int base);
    logic [7:0] r;
    logic w, t;
    int ta, tb, m, k, win, retries, p;
    bit tmo, tie_;
    ent_t e;
    r = '0; w = 1'b0; t = 1'b0;
    for (int b = 0; b < NB; b++) begin
      p = (base + b) % (1 << PW);
      retries = 0;
      forever begin
        if (rq_a.size() > 0) begin
          ta = rq_a.pop_front();
          tb = rq_b.pop_front();
        end else begin
          ta = 3; tb = 4;
        end
        e = '{S_CLR, b, p, 0, ta, tb, r, w, t};
        exp_q.push_back(e);
        m = (fst(ta) < fst(tb)) ? fst(ta) : fst(tb);
        tmo = (m > WMAX);
        k = tmo ? WMAX : m;
        for (int j = 1; j <= k; j++) begin
          e = '{S_RACE, b, p, j, ta, tb, r, w, t};
          exp_q.push_back(e);
        end
        tie_ = !tmo && (ta == tb);
        win = (!tmo && fst(ta) < fst(tb)) ? 1 : 0;
        if (tmo) w = 1'b1;
        if (tie_) t = 1'b1;
        if (TIE_EN && tie_ && retries < 3) begin
          retries++;
          continue;
        end
        break;
      end
      e = '{S_REC, b, p, 0, 0, 0, r, w, t};
      exp_q.push_back(e);
      r[b] = win[0];
    end
    e = '{S_DONE, 0, 0, 0, 0, 0, r, w, t};
    exp_q.push_back(e);
    last_len = exp_q.size();
  endtask

  always @(posedge clk) begin
    if (!rst && cur_idle && ifc.start) build(int'(ifc.challenge));
  end

  logic tie_act;
`ifdef RO_PUF_TIE_RETRY_EN
  assign tie_act = ifc.tie_seen;
`else
  assign tie_act = 1'b0;
`endif

  always @(negedge clk) begin : cmp
    logic [16:0] act, expv, msk;
    ent_t e;
    act = {ifc.busy, ifc.ctr_rst, ifc.ctr_en, ifc.resp_valid,
           ifc.wdog_err, tie_act, ifc.response, ifc.pair_sel};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cur_idle = 1'b0;
      cur_st = e.st; cur_bit = e.bt; cur_rc = e.rc;
      expv = {1'b1, e.st == S_CLR, e.st == S_RACE, e.st == S_DONE,
              e.werr, TIE_EN ? e.tie : 1'b0, e.resp, 3'(e.pr)};
      msk = (e.st == S_DONE) ? ~17'h7 : '1;
      if (e.st == S_CLR) begin
        ifc.done_a = 1'b0;
        ifc.done_b = 1'b0;
      end else if (e.st == S_RACE) begin
        ifc.done_a = (e.ta != 0) && (e.rc >= e.ta);
        ifc.done_b = (e.tb != 0) && (e.rc >= e.tb);
      end
      if (e.st == S_DONE) begin
        idle_resp = e.resp;
        idle_werr = e.werr;
        idle_tie  = e.tie;
      end
    end else begin
      cur_idle = 1'b1;
      cur_st = 0;
      expv = {4'b0, idle_werr, TIE_EN ? idle_tie : 1'b0, idle_resp, 3'b0};
      msk = ~17'h7;
    end
    if (ifc.ctr_rst === 1'b1) psq.push_back(int'(ifc.pair_sel));
    tests++;
    if ((act & msk) !== (expv & msk)) begin
      fails++;
      $display("FAIL cycle t=%0t st=%0d got=%h expected=%h",
               $time, cur_st, act & msk, expv & msk);
    end
  end

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] x);
    tests++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, a, x);
    end
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (ifc.resp_valid === 1'b1) break;
    end
    if (ifc.resp_valid !== 1'b1) chk("resp_valid_timeout", 0, 1);
  endtask

  task automatic run(input int ch, output int cyc);
    @(negedge clk);
    #1;
    ifc.start = 1'b1;
    ifc.challenge = 3'(ch);
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    wait_valid(cyc);
    @(negedge clk);
  endtask

  task automatic push_race(input int a, input int b);
    rq_a.push_back(a);
    rq_b.push_back(b);
  endtask

  initial begin
    int cyc, pulses, n;
    logic [31:0] ps;
    ifc.start = 1'b0;
    ifc.challenge = '0;
    ifc.done_a = 1'b0;
    ifc.done_b = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", {ifc.busy, ifc.ctr_rst, ifc.ctr_en,
        ifc.resp_valid, ifc.wdog_err, ifc.response, ifc.pair_sel}, 0);
    rst = 1'b0;

    // A first every bit, base 2
    for (int i = 0; i < NB; i++) push_race(5, 0);
    psq.delete();
    run(2, cyc);
    chk("a_first_model_len", last_len, 57);
    chk("a_first_cycles", cyc, 57);
    chk("a_first_resp", ifc.response, 8'hFF);
    ps = '0;
    for (int i = 0; i < 8; i++) ps = (ps << 4) | 32'(psq[i]);
    chk("pair_seq", ps, 32'h23456701);
    chk("pair_seq_len", psq.size(), 8);

    // alternating winners, k=3
    for (int i = 0; i < NB; i++) begin
      if (i % 2 == 0) push_race(0, 3);
      else push_race(3, 0);
    end
    run(0, cyc);
    chk("alt_cycles", cyc, 41);
    chk("alt_resp", ifc.response, 8'hAA);

    // tie on bit 0
    push_race(4, 4);
`ifdef RO_PUF_TIE_RETRY_EN
    push_race(4, 4);
    push_race(2, 5);
`endif
    for (int i = 1; i < NB; i++) push_race(0, 2);
    run(1, cyc);
`ifdef RO_PUF_TIE_RETRY_EN
    chk("tie_resp", ifc.response, 8'h01);
    chk("tie_seen", ifc.tie_seen, 1);
`else
    chk("tie_resp", ifc.response, 8'h00);
`endif

    // watchdog: no done ever
    for (int i = 0; i < NB; i++) push_race(0, 0);
    run(4, cyc);
    chk("wdog_cycles", cyc, 137);
    chk("wdog_resp", ifc.response, 8'h00);
    chk("wdog_err_set", ifc.wdog_err, 1);

    // next start clears wdog_err
    for (int i = 0; i < NB; i++) push_race(1, 2);
    run(7, cyc);
    chk("clr_cycles", cyc, 25);
    chk("clr_resp", ifc.response, 8'hFF);
    chk("wdog_err_clr", ifc.wdog_err, 0);

    // reset in RACE of bit 3
    for (int i = 0; i < NB; i++) push_race(6, 0);
    @(negedge clk);
    #1;
    ifc.start = 1'b1;
    ifc.challenge = 3'd5;
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    n = 0;
    while (n < 500) begin
      @(negedge clk);
      #1;
      n++;
      if (cur_st == S_RACE && cur_bit == 3 && cur_rc == 2) break;
    end
    chk("reach_bit3_race", (cur_st == S_RACE && cur_bit == 3) ? 1 : 0, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_outputs", {ifc.ctr_en, ifc.busy, ifc.response,
        ifc.pair_sel}, 0);
    exp_q.delete();
    rq_a.delete();
    rq_b.delete();
    idle_resp = '0;
    idle_werr = 1'b0;
    idle_tie  = 1'b0;
    cur_idle  = 1'b1;
    ifc.done_a = 1'b0;
    ifc.done_b = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (i % 2 == 0) push_race(2, 0);
      else push_race(0, 2);
    end
    run(6, cyc);
    chk("post_rst_resp", ifc.response, 8'h55);

    // start held through the whole challenge
    for (int i = 0; i < NB; i++) push_race(2, 1);
    @(negedge clk);
    #1;
    ifc.start = 1'b1;
    ifc.challenge = 3'd3;
    pulses = 0;
    wait_valid(cyc);
    if (ifc.resp_valid === 1'b1) pulses++;
    #1;
    ifc.start = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ifc.resp_valid === 1'b1) pulses++;
    end
    chk("held_start_pulses", pulses, 1);
    chk("held_start_resp", ifc.response, 8'h00);

    // randomized races
    for (int c = 0; c < 30; c++) begin
      for (int i = 0; i < 40; i++) begin
        int a, b;
        a = $urandom_range(0, 17);
        b = ($urandom_range(0, 3) == 0) ? a : $urandom_range(0, 17);
        push_race(a, b);
      end
      run($urandom_range(0, 7), cyc);
      rq_a.delete();
      rq_b.delete();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
